// File: rtl/tank_pkg.sv
// tank_pkg: shared types and constants for the tank game blocks.
// Rev 1.0 - initial release.
`default_nettype none

package tank_pkg;

    typedef enum logic [1:0] {UP, LEFT, DOWN, RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, FLY, COOL} shell_state_t;

    localparam logic [15:0] KEY_W    = 16'h001A;
    localparam logic [15:0] KEY_A    = 16'h0004;
    localparam logic [15:0] KEY_S    = 16'h0016;
    localparam logic [15:0] KEY_D    = 16'h0007;
    localparam logic [15:0] KEY_FIRE = 16'h002C;

    localparam int SCREEN_X_MIN = 1;
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MIN = 1;
    localparam int SCREEN_Y_MAX = 479;

endpackage

`default_nettype wire

// File: rtl/tank_shell_if.sv
// tank_shell_if: key, position and shell signals of one tank's shell engine.
// Rev 1.0 - initial release. Carries hit_count when TANK_SHELL_HIT_COUNT_EN is defined.
`default_nettype none

interface tank_shell_if;
    logic [15:0] keycode;
    logic [15:0] firekey;
    logic [9:0]  tankX;
    logic [9:0]  tankY;
    logic [9:0]  otherTankX;
    logic [9:0]  otherTankY;
    logic [9:0]  shellX;
    logic [9:0]  shellY;
    logic        shell_active;
    logic        ball_hit;
`ifdef TANK_SHELL_HIT_COUNT_EN
    logic [7:0]  hit_count;
`endif

    modport master (
        output keycode, firekey, tankX, tankY, otherTankX, otherTankY,
        input  shellX, shellY, shell_active, ball_hit
`ifdef TANK_SHELL_HIT_COUNT_EN
        , input hit_count
`endif
    );

    modport slave (
        input  keycode, firekey, tankX, tankY, otherTankX, otherTankY,
        output shellX, shellY, shell_active, ball_hit
`ifdef TANK_SHELL_HIT_COUNT_EN
        , output hit_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/shell_hit_detect.sv
// shell_hit_detect: combinational box-overlap test of a point against a target centre.
// Rev 1.0 - initial release.
`default_nettype none

module shell_hit_detect #(
    parameter int HALF = 8
) (
    input  wire logic signed [10:0] next_x,
    input  wire logic signed [10:0] next_y,
    input  wire logic [9:0]         target_x,
    input  wire logic [9:0]         target_y,
    output logic                    hit
);
    localparam logic signed [11:0] c_half = 12'(HALF);

    // 12 bits so a negative point minus a large target cannot wrap
    logic signed [11:0] w_dx, w_dy, w_adx, w_ady;

    always_comb begin
        w_dx  = {next_x[10], next_x} - $signed({2'b00, target_x});
        w_dy  = {next_y[10], next_y} - $signed({2'b00, target_y});
        w_adx = w_dx[11] ? -w_dx : w_dx;
        w_ady = w_dy[11] ? -w_dy : w_dy;
        hit   = (w_adx <= c_half) && (w_ady <= c_half);
    end
endmodule

`default_nettype wire

// File: rtl/tank_shell.sv
// tank_shell: launches one shell per fire press, flies it per frame, strobes ball_hit on a hit.
// Rev 1.0 - initial release. Optional hit_count output via TANK_SHELL_HIT_COUNT_EN.
`default_nettype none

module tank_shell
    import tank_pkg::*;
#(
    parameter logic [15:0] FIRE_CODE       = KEY_FIRE,
    parameter int          SHELL_STEP      = 4,
    parameter int          TANK_HALF       = 8,
    parameter int          X_MIN           = SCREEN_X_MIN,
    parameter int          X_MAX           = SCREEN_X_MAX,
    parameter int          Y_MIN           = SCREEN_Y_MIN,
    parameter int          Y_MAX           = SCREEN_Y_MAX,
    parameter int          COOLDOWN_FRAMES = 30
) (
    input  wire logic    frame_clk,
    input  wire logic    Reset,
    tank_shell_if.slave  bus
);
    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CW-1:0]      c_cnt_load = CW'(COOLDOWN_FRAMES - 1);
    localparam logic signed [10:0] c_step     = 11'(SHELL_STEP);
    localparam logic signed [10:0] c_x_min    = 11'(X_MIN);
    localparam logic signed [10:0] c_x_max    = 11'(X_MAX);
    localparam logic signed [10:0] c_y_min    = 11'(Y_MIN);
    localparam logic signed [10:0] c_y_max    = 11'(Y_MAX);

    shell_state_t  r_state, w_state_next;
    dir_t          r_facing, w_facing_next, r_dir, w_dir_next;
    logic [9:0]    r_x, r_y, w_x_next, w_y_next;
    logic          r_active, w_active_next, r_hit, w_hit_next, r_fire_prev;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          w_fire_now, w_fire_evt, w_oob, w_hit;
    logic signed [10:0] w_next_x, w_next_y;

    assign w_fire_now = (bus.firekey == FIRE_CODE);
    assign w_fire_evt = w_fire_now & ~r_fire_prev;

    always_comb begin
        w_next_x = $signed({1'b0, r_x});
        w_next_y = $signed({1'b0, r_y});
        case (r_dir)
            LEFT:    w_next_x = $signed({1'b0, r_x}) - c_step;
            RIGHT:   w_next_x = $signed({1'b0, r_x}) + c_step;
            UP:      w_next_y = $signed({1'b0, r_y}) - c_step;
            default: w_next_y = $signed({1'b0, r_y}) + c_step;
        endcase
        // only the moving axis is bounds-checked
        if (r_dir == LEFT || r_dir == RIGHT)
            w_oob = (w_next_x < c_x_min) || (w_next_x > c_x_max);
        else
            w_oob = (w_next_y < c_y_min) || (w_next_y > c_y_max);
    end

    shell_hit_detect #(.HALF(TANK_HALF)) u_hit (
        .next_x   (w_next_x),
        .next_y   (w_next_y),
        .target_x (bus.otherTankX),
        .target_y (bus.otherTankY),
        .hit      (w_hit)
    );

    always_comb begin
        w_facing_next = r_facing;
        case (bus.keycode)
            KEY_W:   w_facing_next = UP;
            KEY_A:   w_facing_next = LEFT;
            KEY_S:   w_facing_next = DOWN;
            KEY_D:   w_facing_next = RIGHT;
            default: w_facing_next = r_facing;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_dir_next    = r_dir;
        w_active_next = r_active;
        w_hit_next    = 1'b0;
        w_cnt_next    = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_fire_evt) begin
                    w_x_next      = bus.tankX;
                    w_y_next      = bus.tankY;
                    w_dir_next    = r_facing;
                    w_active_next = 1'b1;
                    w_state_next  = FLY;
                end
            end
            FLY: begin
                if (w_oob || w_hit) begin
                    w_hit_next    = ~w_oob;
                    w_active_next = 1'b0;
                    w_cnt_next    = c_cnt_load;
                    w_state_next  = COOL;
                end else begin
                    w_x_next = w_next_x[9:0];
                    w_y_next = w_next_y[9:0];
                end
            end
            COOL: begin
                if (r_cnt == '0) w_state_next = IDLE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_facing    <= RIGHT;
            r_dir       <= RIGHT;
            r_x         <= '0;
            r_y         <= '0;
            r_active    <= 1'b0;
            r_hit       <= 1'b0;
            r_cnt       <= '0;
            r_fire_prev <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_facing    <= w_facing_next;
            r_dir       <= w_dir_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_active    <= w_active_next;
            r_hit       <= w_hit_next;
            r_cnt       <= w_cnt_next;
            r_fire_prev <= w_fire_now;
        end
    end

    assign bus.shellX       = r_x;
    assign bus.shellY       = r_y;
    assign bus.shell_active = r_active;
    assign bus.ball_hit     = r_hit;

`ifdef TANK_SHELL_HIT_COUNT_EN
    logic [7:0] r_hit_count;
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            r_hit_count <= 8'd0;
        else if (w_hit_next && r_hit_count != 8'hFF)
            r_hit_count <= r_hit_count + 8'd1;
    end
    assign bus.hit_count = r_hit_count;
`endif
endmodule

`default_nettype wire

// File: tb/tb_tank_shell.sv
// tb_tank_shell: directed-vector bench for tank_shell.
// Rev 1.0 - initial release.
`default_nettype none

module tb_tank_shell;
    logic frame_clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    tank_shell_if bus();

    tank_shell dut (
        .frame_clk (frame_clk),
        .Reset     (rst),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.firekey = 16'h0000;
        bus.keycode = 16'h0000;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic set_pos(input int tx, input int ty, input int ox, input int oy);
        bus.tankX      = 10'(tx);
        bus.tankY      = 10'(ty);
        bus.otherTankX = 10'(ox);
        bus.otherTankY = 10'(oy);
    endtask

    // sets facing one frame ahead, then presses fire for exactly one frame
    task automatic launch(input logic [15:0] key);
        bus.keycode = key;
        tick();
        bus.firekey = 16'h002C;
        tick();
        bus.firekey = 16'h0000;
    endtask

    initial begin
        int launches;
        logic prev_act;

        rst = 1'b1;
        bus.keycode = 16'h0000;
        bus.firekey = 16'h0000;
        set_pos(0, 0, 500, 400);
        #2;
        check_val("rst_x",      bus.shellX, 0);
        check_val("rst_y",      bus.shellY, 0);
        check_val("rst_active", bus.shell_active, 0);
        check_val("rst_hit",    bus.ball_hit, 0);
        #10 rst = 1'b0;

        // basic flight; keycode switched to W mid-flight must not bend the shell
        set_pos(100, 200, 500, 400);
        launch(16'h0007);
        check_val("fly_active", bus.shell_active, 1);
        check_val("fly_x0", bus.shellX, 100);
        check_val("fly_y0", bus.shellY, 200);
        bus.keycode = 16'h001A;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_val("fly_x", bus.shellX, 32'(100 + 4 * i));
            check_val("fly_y", bus.shellY, 200);
        end
        check_val("fly_nohit", bus.ball_hit, 0);

        // hit at next=132 against target X 140
        apply_reset();
        set_pos(100, 200, 140, 200);
        launch(16'h0007);
        repeat (7) tick();
        check_val("hit_x128", bus.shellX, 128);
        check_val("hit_pre", bus.ball_hit, 0);
        tick();
        check_val("hit_strobe", bus.ball_hit, 1);
        check_val("hit_inactive", bus.shell_active, 0);
        check_val("hit_hold_x", bus.shellX, 128);
        tick();
        check_val("hit_clear", bus.ball_hit, 0);
`ifdef TANK_SHELL_HIT_COUNT_EN
        check_val("hit_count", bus.hit_count, 1);
`endif

        // left boundary: 10 -> 6 -> 2, next -2 retires
        apply_reset();
        set_pos(10, 50, 300, 300);
        launch(16'h0004);
        check_val("bnd_x10", bus.shellX, 10);
        tick();
        check_val("bnd_x6", bus.shellX, 6);
        tick();
        check_val("bnd_x2", bus.shellX, 2);
        tick();
        check_val("bnd_retire", bus.shell_active, 0);
        check_val("bnd_nohit", bus.ball_hit, 0);

        // held fire key: one launch; flight 500..636 retires after 35 frames, cooldown done well before 100
        apply_reset();
        set_pos(500, 200, 100, 400);
        bus.keycode = 16'h0007;
        tick();
        launches = 0;
        prev_act = 1'b0;
        bus.firekey = 16'h002C;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.shell_active && !prev_act) launches++;
            prev_act = bus.shell_active;
        end
        check_val("hold_launches", 32'(launches), 1);
        bus.firekey = 16'h0000;
        check_val("hold_idle", bus.shell_active, 0);

        tick();
        bus.firekey = 16'h002C;
        tick();
        bus.firekey = 16'h0000;
        check_val("cool_launch", bus.shell_active, 1);
        for (int k = 0; k < 100 && bus.shell_active; k++) tick();
        check_val("cool_retired", bus.shell_active, 0);
        repeat (4) tick();
        bus.firekey = 16'h002C;
        tick();
        bus.firekey = 16'h0000;
        check_val("cool_ignore5", bus.shell_active, 0);
        repeat (34) tick();
        check_val("cool_not_queued", bus.shell_active, 0);
        bus.firekey = 16'h002C;
        tick();
        bus.firekey = 16'h0000;
        check_val("cool_relaunch", bus.shell_active, 1);
        check_val("cool_relaunch_x", bus.shellX, 500);

        // async reset mid-flight, then facing must be back to RIGHT
        apply_reset();
        set_pos(100, 200, 500, 400);
        launch(16'h0007);
        repeat (5) tick();
        check_val("mrst_x120", bus.shellX, 120);
        bus.keycode = 16'h0000;
        #2 rst = 1'b1;
        #1;
        check_val("mrst_x", bus.shellX, 0);
        check_val("mrst_y", bus.shellY, 0);
        check_val("mrst_active", bus.shell_active, 0);
        check_val("mrst_hit", bus.ball_hit, 0);
        rst = 1'b0;
        bus.firekey = 16'h002C;
        tick();
        bus.firekey = 16'h0000;
        check_val("mrst_fire", bus.shell_active, 1);
        check_val("mrst_fire_x", bus.shellX, 100);
        tick();
        check_val("mrst_right", bus.shellX, 104);

        // next=640 is out of bounds and inside the box around X 648; boundary wins
        apply_reset();
        set_pos(620, 200, 648, 200);
        launch(16'h0007);
        check_val("sim_x620", bus.shellX, 620);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val("sim_x", bus.shellX, 32'(620 + 4 * i));
        end
        tick();
        check_val("sim_retire", bus.shell_active, 0);
        check_val("sim_nohit", bus.ball_hit, 0);
        tick();
        check_val("sim_nohit2", bus.ball_hit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
